// File: rtl/xfer_sequencer.sv
// Sequences one register-to-register transfer over a shared 12-bit bus built
// from MULTILATCH-style registers: drive source, open destination hold, strobe latch.
module xfer_sequencer #(
  parameter int NREG  = 8,
  parameter int DWELL = 1
) (
  input  logic            SYSCLK,
  input  logic            RESET,
  input  logic            req,
  input  logic [2:0]      src,
  input  logic [2:0]      dst,
  output logic [NREG-1:0] oe,
  output logic [NREG-1:0] hold,
  output logic [NREG-1:0] latch,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, LATCH, RELEASE} state_t;

  localparam logic [NREG-1:0] ALL1 = '1;

  state_t     state;
  logic [2:0] src_q, dst_q;
  logic [3:0] cnt;

  function automatic logic [NREG-1:0] dec(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int k = 0; k < NREG; k++) v[k] = (idx == 3'(k));
    return v;
  endfunction

  // Outputs are loaded with the values of the state being entered, so every
  // output is a flop decoded from state and the captured indices.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      cnt   <= '0;
      oe    <= '0;
      hold  <= ALL1;
      latch <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            src_q <= src;
            dst_q <= dst;
            if (int'(src) < NREG && int'(dst) < NREG) begin
              state <= DRIVE;
              cnt   <= 4'(DWELL - 1);
              oe    <= dec(src);
              busy  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            state <= SAMPLE;
            oe    <= dec(src_q);
            hold  <= ~dec(dst_q);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          // Freeze the holding stage in the same cycle the strobe rises.
          state <= LATCH;
          hold  <= ALL1;
          latch <= dec(dst_q);
        end
        LATCH: begin
          state <= RELEASE;
          oe    <= '0;
          latch <= '0;
          done  <= 1'b1;
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oe    <= '0;
          hold  <= ALL1;
          latch <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_sequencer.sv
// Directed and random checks of xfer_sequencer: A (8 regs, dwell 1),
// B (6 regs, dwell 1), C (8 regs, dwell 3), all sharing one input set.
module tb_xfer_sequencer;

  logic SYSCLK = 1'b0;
  logic RESET  = 1'b0;
  logic req    = 1'b0;
  logic [2:0] src = '0, dst = '0;

  logic [7:0] oe_a, hold_a, latch_a;
  logic [5:0] oe_b, hold_b, latch_b;
  logic [7:0] oe_c, hold_c, latch_c;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b, busy_c, done_c, err_c;

  int total = 0;
  int bad   = 0;

  logic [11:0] regs_a [8];
  logic [11:0] stage_a [8];
  logic [7:0]  lprev_a;

  always #5 SYSCLK = ~SYSCLK;

  xfer_sequencer #(.NREG(8), .DWELL(1)) u_a (
    .SYSCLK(SYSCLK), .RESET(RESET), .req(req), .src(src), .dst(dst),
    .oe(oe_a), .hold(hold_a), .latch(latch_a), .busy(busy_a), .done(done_a), .err(err_a));
  xfer_sequencer #(.NREG(6), .DWELL(1)) u_b (
    .SYSCLK(SYSCLK), .RESET(RESET), .req(req), .src(src), .dst(dst),
    .oe(oe_b), .hold(hold_b), .latch(latch_b), .busy(busy_b), .done(done_b), .err(err_b));
  xfer_sequencer #(.NREG(8), .DWELL(3)) u_c (
    .SYSCLK(SYSCLK), .RESET(RESET), .req(req), .src(src), .dst(dst),
    .oe(oe_c), .hold(hold_c), .latch(latch_c), .busy(busy_c), .done(done_c), .err(err_c));

  task automatic idle_wait(input int n);
    req = 1'b0;
    repeat (n) @(negedge SYSCLK);
  endtask

  // Physical bus model for A: one cycle of the eight MULTILATCH registers.
  task automatic model_a();
    logic [11:0] bus;
    bus = '0;
    for (int i = 0; i < 8; i++) if (oe_a[i]) bus = regs_a[i];
    for (int i = 0; i < 8; i++) begin
      if (!hold_a[i]) stage_a[i] = bus;
      if (latch_a[i] && !lprev_a[i]) regs_a[i] = stage_a[i];
    end
    lprev_a = latch_a;
  endtask

  task automatic test_reset();
    @(negedge SYSCLK);
    RESET = 1'b1; req = 1'b1; src = 3'd1; dst = 3'd2;
    repeat (2) @(negedge SYSCLK);
    total++;
    if ({oe_a, latch_a, hold_a, busy_a, done_a, err_a} !== {8'h00, 8'h00, 8'hFF, 3'b000}) begin
      bad++; $display("FAIL reset_a got oe=%h latch=%h hold=%h b/d/e=%b%b%b want 00 00 ff 000",
                      oe_a, latch_a, hold_a, busy_a, done_a, err_a);
    end
    total++;
    if ({oe_b, latch_b, hold_b, busy_b, done_b, err_b} !== {6'h00, 6'h00, 6'h3F, 3'b000}) begin
      bad++; $display("FAIL reset_b got oe=%h latch=%h hold=%h b/d/e=%b%b%b want 00 00 3f 000",
                      oe_b, latch_b, hold_b, busy_b, done_b, err_b);
    end
    total++;
    if ({oe_c, latch_c, hold_c, busy_c, done_c, err_c} !== {8'h00, 8'h00, 8'hFF, 3'b000}) begin
      bad++; $display("FAIL reset_c got oe=%h latch=%h hold=%h b/d/e=%b%b%b want 00 00 ff 000",
                      oe_c, latch_c, hold_c, busy_c, done_c, err_c);
    end
    RESET = 1'b0; req = 1'b0;
    @(negedge SYSCLK);
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_prio busy got=%b want=0", busy_a);
    end
  endtask

  task automatic test_single();
    logic [7:0] e_oe, e_hold, e_latch;
    req = 1'b1; src = 3'd2; dst = 3'd5;
    @(negedge SYSCLK);
    req = 1'b0; src = 3'd7; dst = 3'd0;
    for (int c = 1; c <= 5; c++) begin
      e_oe    = (c <= 3) ? 8'h04 : 8'h00;
      e_hold  = (c == 2) ? 8'hDF : 8'hFF;
      e_latch = (c == 3) ? 8'h20 : 8'h00;
      total++;
      if (oe_a !== e_oe) begin
        bad++; $display("FAIL single oe c=%0d got=%h want=%h", c, oe_a, e_oe);
      end
      total++;
      if (hold_a !== e_hold) begin
        bad++; $display("FAIL single hold c=%0d got=%h want=%h", c, hold_a, e_hold);
      end
      total++;
      if (latch_a !== e_latch) begin
        bad++; $display("FAIL single latch c=%0d got=%h want=%h", c, latch_a, e_latch);
      end
      total++;
      if ({busy_a, done_a, err_a} !== {c <= 4, c == 4, 1'b0}) begin
        bad++; $display("FAIL single busy/done/err c=%0d got=%b%b%b want=%b%b0",
                        c, busy_a, done_a, err_a, c <= 4, c == 4);
      end
      @(negedge SYSCLK);
    end
    idle_wait(8);
  endtask

  task automatic test_reject();
    req = 1'b1; src = 3'd1; dst = 3'd7;
    @(negedge SYSCLK);
    req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      total++;
      if (err_b !== (c == 1)) begin
        bad++; $display("FAIL reject err c=%0d got=%b want=%b", c, err_b, c == 1);
      end
      total++;
      if ({busy_b, done_b, oe_b, latch_b, hold_b} !== {2'b00, 6'h00, 6'h00, 6'h3F}) begin
        bad++; $display("FAIL reject quiet c=%0d got busy=%b done=%b oe=%h latch=%h hold=%h want 0 0 00 00 3f",
                        c, busy_b, done_b, oe_b, latch_b, hold_b);
      end
      @(negedge SYSCLK);
    end
    idle_wait(8);
  endtask

  task automatic test_back_to_back();
    logic [11:0] r0, st0;
    logic        lp;
    int          p, ndone;
    r0 = 12'hABC; st0 = r0; lp = 1'b0; ndone = 0;
    req = 1'b1; src = 3'd0; dst = 3'd0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge SYSCLK);
      p = (c - 1) % 7;
      if (!hold_c[0]) st0 = oe_c[0] ? r0 : 12'h000;
      if (latch_c[0] && !lp) r0 = st0;
      lp = latch_c[0];
      total++;
      if ({oe_c, hold_c, latch_c} !== {(p <= 4) ? 8'h01 : 8'h00, (p == 3) ? 8'hFE : 8'hFF,
                                        (p == 4) ? 8'h01 : 8'h00}) begin
        bad++; $display("FAIL b2b pins c=%0d got oe=%h hold=%h latch=%h phase=%0d", c, oe_c, hold_c, latch_c, p);
      end
      total++;
      if ({busy_c, done_c} !== {p != 6, p == 5}) begin
        bad++; $display("FAIL b2b busy/done c=%0d got=%b%b want=%b%b", c, busy_c, done_c, p != 6, p == 5);
      end
      if (done_c) begin
        ndone++;
        total++;
        if (r0 !== 12'hABC) begin
          bad++; $display("FAIL b2b value c=%0d got=%h want=abc", c, r0);
        end
      end
    end
    total++;
    if (ndone != 3) begin
      bad++; $display("FAIL b2b done_count got=%0d want=3", ndone);
    end
    idle_wait(10);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; src = 3'd3; dst = 3'd4;
    @(negedge SYSCLK);
    req = 1'b0;
    @(negedge SYSCLK);
    RESET = 1'b1;
    @(negedge SYSCLK);
    RESET = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({oe_a, latch_a, hold_a, busy_a, done_a} !== {8'h00, 8'h00, 8'hFF, 2'b00}) begin
        bad++; $display("FAIL reset_mid c=%0d got oe=%h latch=%h hold=%h busy=%b done=%b want 00 00 ff 0 0",
                        c, oe_a, latch_a, hold_a, busy_a, done_a);
      end
      @(negedge SYSCLK);
    end
    req = 1'b1;
    @(negedge SYSCLK);
    req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      total++;
      if ({latch_a, done_a} !== {(c == 3) ? 8'h10 : 8'h00, c == 4}) begin
        bad++; $display("FAIL reset_mid_retry c=%0d got latch=%h done=%b want latch=%h done=%b",
                        c, latch_a, done_a, (c == 3) ? 8'h10 : 8'h00, c == 4);
      end
      @(negedge SYSCLK);
    end
    idle_wait(6);
  endtask

  task automatic test_random();
    int          phase, sd, dd, inv_bad, val_bad, ndone;
    logic [11:0] val;
    phase = 0; sd = 0; dd = 0; val = '0; inv_bad = 0; val_bad = 0; ndone = 0;
    for (int i = 0; i < 8; i++) begin
      regs_a[i]  = 12'($urandom);
      stage_a[i] = regs_a[i];
    end
    lprev_a = '0;
    for (int n = 0; n < 10000; n++) begin
      if ($countones(oe_a) > 1 || $countones(latch_a) > 1 ||
          (latch_a != 8'h00 && hold_a != 8'hFF) || (done_a && err_a) ||
          busy_a !== (phase != 0) || done_a !== (phase == 4)) begin
        inv_bad++;
        if (inv_bad <= 5)
          $display("FAIL random pins n=%0d oe=%h hold=%h latch=%h busy=%b done=%b err=%b model_phase=%0d",
                   n, oe_a, hold_a, latch_a, busy_a, done_a, err_a, phase);
      end
      model_a();
      if (phase == 4) begin
        ndone++;
        if (regs_a[dd] !== val) begin
          val_bad++;
          if (val_bad <= 5)
            $display("FAIL random value n=%0d src=%0d dst=%0d got=%h want=%h", n, sd, dd, regs_a[dd], val);
        end
      end
      RESET = ($urandom_range(0, 49) == 0);
      req   = ($urandom_range(0, 2) != 0);
      src   = 3'($urandom_range(0, 7));
      dst   = 3'($urandom_range(0, 7));
      if (RESET) phase = 0;
      else if (phase == 0) begin
        if (req) begin
          phase = 1; sd = int'(src); dd = int'(dst); val = regs_a[src];
        end
      end else phase = (phase == 4) ? 0 : phase + 1;
      @(negedge SYSCLK);
    end
    RESET = 1'b0; req = 1'b0;
    total++;
    if (inv_bad != 0) begin
      bad++; $display("FAIL random pins violations got=%0d want=0", inv_bad);
    end
    total++;
    if (val_bad != 0) begin
      bad++; $display("FAIL random value errors got=%0d want=0", val_bad);
    end
    total++;
    if (ndone < 100) begin
      bad++; $display("FAIL random done_count got=%0d want>=100", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
